alu_issue_ctrl: RTL and testbench

//  Initiator side of the combinational ALU interface. Accepts one MIPS instruction at a time

---
 rtl/alu_issue_ctrl_if.sv | 40 ++++
 rtl/alu_issue_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl_if
// Groups the instruction handshake, the ALU drive/return bus and the
// completion report of alu_issue_ctrl into one bundle.
//   instr_valid/instr_ready/instr       instruction source handshake
//   alu_instruction/alu_rega/alu_regb   controller -> ALU
//   alu_result/alu_flags                ALU -> controller
//   done/done_result/done_flags/
//   branch_taken/ovf_trap/illegal       completion report
// The master modport is the controller side. The slave modport is the
// environment side, which holds the instruction source and the ALU.
// ----------------------------------------------------------------------------
interface alu_issue_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_instruction;
    logic [31:0] alu_rega;
    logic [31:0] alu_regb;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;
    logic        done;
    logic [31:0] done_result;
    logic [2:0]  done_flags;
    logic        branch_taken;
    logic        ovf_trap;
    logic        illegal;

    modport master (
        input  instr_valid, instr, alu_result, alu_flags,
        output instr_ready, alu_instruction, alu_rega, alu_regb,
               done, done_result, done_flags, branch_taken, ovf_trap, illegal
    );

    modport slave (
        output instr_valid, instr, alu_result, alu_flags,
        input  instr_ready, alu_instruction, alu_rega, alu_regb,
               done, done_result, done_flags, branch_taken, ovf_trap, illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
// This block is the issuing side of a combinational MIPS ALU. It works on one
// instruction at a time:
//   1. It accepts an instruction over a valid/ready handshake.
//   2. It reads rs and rt from an internal 32x32 register file.
//   3. It presents the instruction and both operands to the ALU.
//   4. After SETTLE_CYC cycles it captures the ALU result and flags.
//   5. It writes the result back and pulses done.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   bus (master)        handshake, ALU drive/return, completion report
//   dbg_addr, dbg_data  combinational debug read of the register file
//
// Parameters:
//   NUM_REGS    register-file entries. Fixed at 32 because specifiers are
//               5 bits wide.
//   SETTLE_CYC  number of cycles the ALU inputs are held before capture (1..4)
// ----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int NUM_REGS   = 32,
    parameter int SETTLE_CYC = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_issue_ctrl_if.master       bus,
    input  logic [4:0]             dbg_addr,
    output logic [31:0]            dbg_data
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        CAPTURE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYC - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    state_t      state;
    state_t      state_next;
    logic [2:0]  settle_cnt;
    logic        accept;

    logic [31:0] rf [NUM_REGS];

    // Only the instruction fields the controller decodes are latched.
    // The ALU gets the full word through alu_instruction.
    logic [5:0]  op_q;
    logic [5:0]  fn_q;
    logic [4:0]  rt_q;
    logic [4:0]  rd_q;

    logic        wb_en_q;
    logic [4:0]  wb_dest_q;

    logic [4:0]  dec_dest;
    logic        dec_write_alu;
    logic        dec_slt;
    logic        dec_trap;
    logic        dec_beq;
    logic        dec_bne;
    logic        dec_illegal;

    logic [31:0] cap_val;
    logic        cap_wr;
    logic        cap_taken;
    logic        cap_ovf;

    assign accept          = bus.instr_valid && bus.instr_ready;
    assign bus.instr_ready = (state == IDLE);

    // r0 is never written. It is also masked on read so that it always reads 0.
    function automatic logic [31:0] read_reg(input logic [4:0] addr);
        return (addr == 5'd0) ? 32'd0 : rf[addr];
    endfunction

    assign dbg_data = read_reg(dbg_addr);

    // State register and settle counter.
    // The counter restarts on every accept and advances only while in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                settle_cnt <= '0;
            end else if (state == ISSUE) begin
                settle_cnt <= settle_cnt + 3'd1;
            end
        end
    end

    // Next-state logic. Each state after ISSUE lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept) state_next = ISSUE;
            ISSUE:     if (settle_cnt == SETTLE_LAST) state_next = CAPTURE;
            CAPTURE:   state_next = WRITEBACK;
            WRITEBACK: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Latch the instruction and drive the ALU on the accept edge.
    // The operands come from the register file, which already holds the
    // previous instruction's writeback at this point.
    // bne is presented to the ALU as beq (opcode 000100); its outcome is
    // inverted at capture instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q                <= '0;
            fn_q                <= '0;
            rt_q                <= '0;
            rd_q                <= '0;
            bus.alu_instruction <= '0;
            bus.alu_rega        <= '0;
            bus.alu_regb        <= '0;
        end else if (accept) begin
            op_q         <= bus.instr[31:26];
            fn_q         <= bus.instr[5:0];
            rt_q         <= bus.instr[20:16];
            rd_q         <= bus.instr[15:11];
            bus.alu_rega <= read_reg(bus.instr[25:21]);
            bus.alu_regb <= read_reg(bus.instr[20:16]);
            if (bus.instr[31:26] == OP_BNE) begin
                bus.alu_instruction <= {OP_BEQ, bus.instr[25:0]};
            end else begin
                bus.alu_instruction <= bus.instr;
            end
        end
    end

    // Decode the instruction class and the destination register.
    // R-type instructions write rd; I-type instructions write rt.
    always_comb begin
        dec_dest      = rt_q;
        dec_write_alu = 1'b0;
        dec_slt       = 1'b0;
        dec_trap      = 1'b0;
        dec_beq       = 1'b0;
        dec_bne       = 1'b0;
        dec_illegal   = 1'b0;
        case (op_q)
            OP_RTYPE: begin
                dec_dest = rd_q;
                case (fn_q)
                    6'h20, 6'h22: begin
                        dec_write_alu = 1'b1;
                        dec_trap      = 1'b1;
                    end
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07:
                        dec_write_alu = 1'b1;
                    6'h2A, 6'h2B:
                        dec_slt = 1'b1;
                    default:
                        dec_illegal = 1'b1;
                endcase
            end
            6'h08: begin
                dec_write_alu = 1'b1;
                dec_trap      = 1'b1;
            end
            6'h09, 6'h0C, 6'h0D, 6'h0E: dec_write_alu = 1'b1;
            6'h0A, 6'h0B:               dec_slt       = 1'b1;
            OP_BEQ:                     dec_beq       = 1'b1;
            OP_BNE:                     dec_bne       = 1'b1;
            // lw/sw report the effective address and write nothing back.
            6'h23, 6'h2B:               ;
            default:                    dec_illegal   = 1'b1;
        endcase
    end

    // Map the live ALU return onto what will be reported and written back.
    // An overflowing add, sub or addi still reports the raw sum, but it does
    // not write it back.
    always_comb begin
        cap_val   = bus.alu_result;
        cap_wr    = 1'b0;
        cap_taken = 1'b0;
        cap_ovf   = 1'b0;
        if (dec_illegal) begin
            cap_wr = 1'b0;
        end else if (dec_slt) begin
            cap_val = {31'd0, bus.alu_flags[1]};
            cap_wr  = 1'b1;
        end else if (dec_write_alu) begin
            if (dec_trap && bus.alu_flags[2]) begin
                cap_ovf = 1'b1;
            end else begin
                cap_wr = 1'b1;
            end
        end else if (dec_beq) begin
            cap_taken = bus.alu_flags[0];
        end else if (dec_bne) begin
            cap_taken = ~bus.alu_flags[0];
        end
    end

    // Register the completion report on the edge that leaves CAPTURE, so
    // that it is valid during WRITEBACK.
    // The status bits are single-cycle pulses alongside done.
    // done_result and done_flags hold their values until the next done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.done         <= 1'b0;
            bus.done_result  <= '0;
            bus.done_flags   <= '0;
            bus.branch_taken <= 1'b0;
            bus.ovf_trap     <= 1'b0;
            bus.illegal      <= 1'b0;
            wb_en_q          <= 1'b0;
            wb_dest_q        <= '0;
        end else if (state == CAPTURE) begin
            bus.done         <= 1'b1;
            bus.done_result  <= cap_val;
            bus.done_flags   <= bus.alu_flags;
            bus.branch_taken <= cap_taken;
            bus.ovf_trap     <= cap_ovf;
            bus.illegal      <= dec_illegal;
            wb_en_q          <= cap_wr && (dec_dest != 5'd0);
            wb_dest_q        <= dec_dest;
        end else begin
            bus.done         <= 1'b0;
            bus.branch_taken <= 1'b0;
            bus.ovf_trap     <= 1'b0;
            bus.illegal      <= 1'b0;
            wb_en_q          <= 1'b0;
        end
    end

    // Register file.
    // The write happens on the edge that leaves WRITEBACK.
    // A reset that arrives mid-instruction clears the file before any write
    // can occur.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else if ((state == WRITEBACK) && wb_en_q) begin
            rf[wb_dest_q] <= bus.done_result;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl.
// A small behavioural ALU answers whatever the controller presents on the
// ALU bus. Each instruction is issued through applyStimulus. Expected values
// are hand-computed constants that are compared through checkOutput.
// ----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int errors = 0;
    int checks = 0;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.master),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU covering the operations the directed vectors use.
    // Opcode 000101 (bne) is deliberately unknown to the ALU, so a
    // controller that forgets to remap bne produces a wrong outcome.
    logic [31:0] m_bop;
    logic [31:0] m_res;
    logic        m_ltu;
    logic        m_add;

    always_comb begin
        m_res = '0;
        m_ltu = 1'b0;
        m_add = 1'b0;
        if (bus.alu_instruction[31:26] == 6'h00 || bus.alu_instruction[31:26] == 6'h04) begin
            m_bop = bus.alu_regb;
        end else begin
            m_bop = {{16{bus.alu_instruction[15]}}, bus.alu_instruction[15:0]};
        end
        case (bus.alu_instruction[31:26])
            6'h00: begin
                case (bus.alu_instruction[5:0])
                    6'h20, 6'h21: begin
                        m_res = bus.alu_rega + m_bop;
                        m_add = 1'b1;
                    end
                    6'h22, 6'h23: m_res = bus.alu_rega - m_bop;
                    6'h24:        m_res = bus.alu_rega & m_bop;
                    6'h25:        m_res = bus.alu_rega | m_bop;
                    6'h2A:        m_res = bus.alu_rega - m_bop;
                    6'h2B: begin
                        m_res = bus.alu_rega - m_bop;
                        m_ltu = 1'b1;
                    end
                    6'h00:        m_res = m_bop << bus.alu_instruction[10:6];
                    6'h02:        m_res = m_bop >> bus.alu_instruction[10:6];
                    default:      m_res = '0;
                endcase
            end
            6'h08, 6'h09: begin
                m_res = bus.alu_rega + m_bop;
                m_add = 1'b1;
            end
            6'h04:        m_res = bus.alu_rega - m_bop;
            6'h23, 6'h2B: m_res = bus.alu_rega + m_bop;
            default:      m_res = '0;
        endcase
    end

    assign bus.alu_result   = m_res;
    assign bus.alu_flags[0] = (m_res == 32'd0);
    assign bus.alu_flags[1] = m_ltu ? (bus.alu_rega < m_bop)
                                    : ($signed(bus.alu_rega) < $signed(m_bop));
    assign bus.alu_flags[2] = m_add && (bus.alu_rega[31] == m_bop[31])
                                    && (m_res[31] != bus.alu_rega[31]);

    // Instruction encoders.
    function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reads one register through the debug port.
    task automatic readReg(input logic [4:0] addr, output logic [31:0] data);
        dbg_addr = addr;
        #1;
        data = dbg_data;
    endtask

    // Issues one instruction and waits for its done pulse.
    // Returns the report captured in the done cycle, the number of negedges
    // from the handshake to done, and the ALU opcode seen in that cycle.
    // The task ends one cycle later, after the writeback has landed.
    task automatic applyStimulus(input logic [31:0] word, output int lat,
                                 output logic [31:0] res, output logic [2:0] flg,
                                 output logic bt, output logic ovf, output logic ill,
                                 output logic [5:0] aluOp);
        int t;
        @(negedge clk);
        bus.instr       = word;
        bus.instr_valid = 1'b1;
        t = 0;
        while (!bus.instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) checkOutput("handshake_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.done && lat < 20);
        if (!bus.done) checkOutput("done_timeout", 32'd0, 32'd1);
        res   = bus.done_result;
        flg   = bus.done_flags;
        bt    = bus.branch_taken;
        ovf   = bus.ovf_trap;
        ill   = bus.illegal;
        aluOp = bus.alu_instruction[31:26];
        @(negedge clk);
        checkOutput("done_single_pulse", {31'd0, bus.done}, 32'd0);
    endtask

    int          lat;
    logic [31:0] res;
    logic [31:0] rv;
    logic [2:0]  flg;
    logic        bt, ovf, ill;
    logic [5:0]  aop;
    int          accepts;
    int          sawDone;

    initial begin
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        dbg_addr        = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state.
        checkOutput("rst_ready",       {31'd0, bus.instr_ready}, 32'd1);
        checkOutput("rst_done",        {31'd0, bus.done}, 32'd0);
        checkOutput("rst_done_result", bus.done_result, 32'd0);
        checkOutput("rst_alu_instr",   bus.alu_instruction, 32'd0);

        // Case 1: addi r1,r0,5 is aborted by a reset during ISSUE.
        bus.instr       = iType(6'h08, 5'd0, 5'd1, 16'd5);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) sawDone++;
        end
        checkOutput("abort_no_done", sawDone, 32'd0);
        checkOutput("abort_ready",   {31'd0, bus.instr_ready}, 32'd1);
        readReg(5'd1, rv);
        checkOutput("abort_r1", rv, 32'd0);

        // Case 2: addi r1,r0,0x7FFF, then add r2,r1,r1.
        applyStimulus(iType(6'h08, 5'd0, 5'd1, 16'h7FFF), lat, res, flg, bt, ovf, ill, aop);
        checkOutput("addi_latency", lat, 32'd3);
        checkOutput("addi_result",  res, 32'h0000_7FFF);
        readReg(5'd1, rv);
        checkOutput("addi_r1", rv, 32'h0000_7FFF);
        applyStimulus(rType(5'd1, 5'd1, 5'd2, 5'd0, 6'h20), lat, res, flg, bt, ovf, ill, aop);
        checkOutput("add_latency", lat, 32'd3);
        readReg(5'd2, rv);
        checkOutput("add_r2", rv, 32'h0000_FFFE);

        // Case 3: build r3=0x7FFFFFFF; add overflows and traps; addu writes.
        applyStimulus(iType(6'h08, 5'd0, 5'd3, 16'hFFFF), lat, res, flg, bt, ovf, ill, aop);
        applyStimulus(rType(5'd0, 5'd3, 5'd3, 5'd1, 6'h02), lat, res, flg, bt, ovf, ill, aop);
        readReg(5'd3, rv);
        checkOutput("srl_r3", rv, 32'h7FFF_FFFF);
        applyStimulus(rType(5'd3, 5'd3, 5'd4, 5'd0, 6'h20), lat, res, flg, bt, ovf, ill, aop);
        checkOutput("add_ovf_trap",   {31'd0, ovf}, 32'd1);
        checkOutput("add_ovf_result", res, 32'hFFFF_FFFE);
        checkOutput("add_ovf_flags",  {29'd0, flg}, 32'd4);
        readReg(5'd4, rv);
        checkOutput("add_ovf_r4", rv, 32'd0);
        applyStimulus(rType(5'd3, 5'd3, 5'd4, 5'd0, 6'h21), lat, res, flg, bt, ovf, ill, aop);
        checkOutput("addu_no_trap", {31'd0, ovf}, 32'd0);
        readReg(5'd4, rv);
        checkOutput("addu_r4", rv, 32'hFFFF_FFFE);

        // Case 4: r5=-1, r6=1; slt gives 1, sltu gives 0.
        applyStimulus(iType(6'h08, 5'd0, 5'd5, 16'hFFFF), lat, res, flg, bt, ovf, ill, aop);
        applyStimulus(iType(6'h08, 5'd0, 5'd6, 16'd1), lat, res, flg, bt, ovf, ill, aop);
        applyStimulus(rType(5'd5, 5'd6, 5'd7, 5'd0, 6'h2A), lat, res, flg, bt, ovf, ill, aop);
        readReg(5'd7, rv);
        checkOutput("slt_r7", rv, 32'd1);
        applyStimulus(rType(5'd5, 5'd6, 5'd7, 5'd0, 6'h2B), lat, res, flg, bt, ovf, ill, aop);
        readReg(5'd7, rv);
        checkOutput("sltu_r7", rv, 32'd0);

        // Case 5: beq and bne with equal operands, then with unequal ones.
        applyStimulus(iType(6'h08, 5'd0, 5'd5, 16'd9), lat, res, flg, bt, ovf, ill, aop);
        applyStimulus(iType(6'h08, 5'd0, 5'd6, 16'd9), lat, res, flg, bt, ovf, ill, aop);
        applyStimulus(iType(6'h04, 5'd5, 5'd6, 16'd3), lat, res, flg, bt, ovf, ill, aop);
        checkOutput("beq_eq_taken", {31'd0, bt}, 32'd1);
        checkOutput("beq_alu_op",   {26'd0, aop}, 32'h04);
        applyStimulus(iType(6'h05, 5'd5, 5'd6, 16'd3), lat, res, flg, bt, ovf, ill, aop);
        checkOutput("bne_eq_taken", {31'd0, bt}, 32'd0);
        checkOutput("bne_alu_op",   {26'd0, aop}, 32'h04);
        readReg(5'd6, rv);
        checkOutput("bne_no_write_r6", rv, 32'd9);
        applyStimulus(iType(6'h08, 5'd0, 5'd6, 16'd8), lat, res, flg, bt, ovf, ill, aop);
        applyStimulus(iType(6'h04, 5'd5, 5'd6, 16'd3), lat, res, flg, bt, ovf, ill, aop);
        checkOutput("beq_ne_taken", {31'd0, bt}, 32'd0);
        applyStimulus(iType(6'h05, 5'd5, 5'd6, 16'd3), lat, res, flg, bt, ovf, ill, aop);
        checkOutput("bne_ne_taken", {31'd0, bt}, 32'd1);

        // Case 6: a write to r0 is discarded; funct 0x3F is illegal.
        applyStimulus(iType(6'h08, 5'd0, 5'd0, 16'd7), lat, res, flg, bt, ovf, ill, aop);
        checkOutput("r0_done_result", res, 32'd7);
        readReg(5'd0, rv);
        checkOutput("r0_dbg", rv, 32'd0);
        applyStimulus(rType(5'd5, 5'd6, 5'd9, 5'd0, 6'h3F), lat, res, flg, bt, ovf, ill, aop);
        checkOutput("illegal_flag",   {31'd0, ill}, 32'd1);
        checkOutput("illegal_branch", {31'd0, bt}, 32'd0);
        readReg(5'd9, rv);
        checkOutput("illegal_r9", rv, 32'd0);

        // Case 6 (cont.): addi r8,r8,1 with valid held high while busy.
        // It must be accepted exactly once.
        @(negedge clk);
        bus.instr       = iType(6'h08, 5'd8, 5'd8, 16'd1);
        bus.instr_valid = 1'b1;
        accepts = 0;
        sawDone = 0;
        for (int i = 0; i < 20 && sawDone == 0; i++) begin
            if (bus.instr_ready && bus.instr_valid) accepts++;
            @(negedge clk);
            if (bus.done) sawDone = 1;
        end
        bus.instr_valid = 1'b0;
        checkOutput("held_valid_done",    sawDone, 32'd1);
        checkOutput("held_valid_accepts", accepts, 32'd1);
        repeat (2) @(negedge clk);
        readReg(5'd8, rv);
        checkOutput("held_valid_r8", rv, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
